countdown_ctrl: RTL and testbench

Run/pause/clear controller and BCD datapath for an mm:ss countdown timer. Takes debounced one-pulse button events and a 1 Hz enable tick, all in the `clk` domain. Sequences the four BCD digits through a 4-state FSM. Drives the digit values to the scan/display logic, plus an LED status pattern and a done flag.

---
 rtl/countdown_ctrl.sv | 129 ++++++++++++
 tb/tb_countdown_ctrl.sv | 181 ++++++++++++++++++
 2 files changed

// File: rtl/countdown_ctrl.sv
`default_nettype none
// ============================================================================
// countdown_ctrl : run/pause/clear FSM and BCD mm:ss datapath for a countdown
// Rev 1.0
// ============================================================================
module countdown_ctrl #(
   parameter logic [3:0] PRESET_M1 = 4'd0,
   parameter logic [3:0] PRESET_M0 = 4'd0,
   parameter logic [3:0] PRESET_S1 = 4'd3,
   parameter logic [3:0] PRESET_S0 = 4'd0
) (
   input  logic        clk,
   input  logic        rst_h,
   input  logic        tick_1hz,
   input  logic        start_pb,
   input  logic        clr_pb,
   output logic [3:0]  m1,
   output logic [3:0]  m0,
   output logic [3:0]  s1,
   output logic [3:0]  s0,
   output logic [1:0]  state,
   output logic        done,
   output logic [15:0] led
);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      RUN   = 2'd1,
      PAUSE = 2'd2,
      DONE  = 2'd3
   } state_t;

   localparam logic [15:0] c_led_off   = 16'h0000;
   localparam logic [15:0] c_led_run   = 16'h0001;
   localparam logic [15:0] c_led_pause = 16'h8001;
   localparam logic [15:0] c_led_on    = 16'hFFFF;
   localparam logic        c_preset_zero = (PRESET_M1 == 4'd0) && (PRESET_M0 == 4'd0) &&
                                           (PRESET_S1 == 4'd0) && (PRESET_S0 == 4'd0);

   state_t     r_state;
   logic       r_blink;
   logic [3:0] w_m1, w_m0, w_s1, w_s0;
   logic       w_dec_zero;

   // One-second decrement with BCD borrow chain; m1 never wraps since 00:00 is never decremented.
   always_comb begin
      w_s0 = (s0 == 4'd0) ? 4'd9 : s0 - 4'd1;
      w_s1 = s1;
      w_m0 = m0;
      w_m1 = m1;
      if (s0 == 4'd0) begin
         w_s1 = (s1 == 4'd0) ? 4'd5 : s1 - 4'd1;
         if (s1 == 4'd0) begin
            w_m0 = (m0 == 4'd0) ? 4'd9 : m0 - 4'd1;
            if (m0 == 4'd0 && m1 != 4'd0) begin
               w_m1 = m1 - 4'd1;
            end
         end
      end
      w_dec_zero = (w_m1 == 4'd0) && (w_m0 == 4'd0) && (w_s1 == 4'd0) && (w_s0 == 4'd0);
   end

   assign state = r_state;

   always_ff @(posedge clk) begin
      if (rst_h || clr_pb) begin
         r_state <= IDLE;
         m1      <= PRESET_M1;
         m0      <= PRESET_M0;
         s1      <= PRESET_S1;
         s0      <= PRESET_S0;
         done    <= 1'b0;
         led     <= c_led_off;
         r_blink <= 1'b0;
      end else begin
         case (r_state)
            IDLE: begin
               if (start_pb) begin
                  if (c_preset_zero) begin
                     r_state <= DONE;
                     done    <= 1'b1;
                     r_blink <= 1'b1;
                     led     <= c_led_on;
                  end else begin
                     r_state <= RUN;
                     led     <= c_led_run;
                  end
               end
            end
            RUN: begin
               if (tick_1hz) begin
                  m1 <= w_m1;
                  m0 <= w_m0;
                  s1 <= w_s1;
                  s0 <= w_s0;
               end
               // Reaching 00:00 outranks a pause requested in the same cycle.
               if (tick_1hz && w_dec_zero) begin
                  r_state <= DONE;
                  done    <= 1'b1;
                  r_blink <= 1'b1;
                  led     <= c_led_on;
               end else if (start_pb) begin
                  r_state <= PAUSE;
                  led     <= c_led_pause;
               end
            end
            PAUSE: begin
               if (start_pb) begin
                  r_state <= RUN;
                  led     <= c_led_run;
               end
            end
            DONE: begin
               if (tick_1hz) begin
                  r_blink <= ~r_blink;
                  led     <= r_blink ? c_led_off : c_led_on;
               end
            end
            default: begin
               r_state <= IDLE;
               led     <= c_led_off;
            end
         endcase
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_countdown_ctrl.sv
`default_nettype none
// Testbench for countdown_ctrl: four instances with different presets checked against
// a seconds-count reference model through a scoreboard queue.
module tb_countdown_ctrl;

   localparam int NI = 4;

   logic clk = 1'b0;
   logic rst_h = 1'b1, tick_1hz = 1'b0, start_pb = 1'b0, clr_pb = 1'b0;

   logic [3:0]  o_m1 [NI];
   logic [3:0]  o_m0 [NI];
   logic [3:0]  o_s1 [NI];
   logic [3:0]  o_s0 [NI];
   logic [1:0]  o_st [NI];
   logic        o_done [NI];
   logic [15:0] o_led [NI];

   always #5 clk = ~clk;

   countdown_ctrl u_p0030 (
      .clk(clk), .rst_h(rst_h), .tick_1hz(tick_1hz), .start_pb(start_pb), .clr_pb(clr_pb),
      .m1(o_m1[0]), .m0(o_m0[0]), .s1(o_s1[0]), .s0(o_s0[0]),
      .state(o_st[0]), .done(o_done[0]), .led(o_led[0]));

   countdown_ctrl #(.PRESET_M1(4'd1), .PRESET_M0(4'd0), .PRESET_S1(4'd0), .PRESET_S0(4'd0)) u_p1000 (
      .clk(clk), .rst_h(rst_h), .tick_1hz(tick_1hz), .start_pb(start_pb), .clr_pb(clr_pb),
      .m1(o_m1[1]), .m0(o_m0[1]), .s1(o_s1[1]), .s0(o_s0[1]),
      .state(o_st[1]), .done(o_done[1]), .led(o_led[1]));

   countdown_ctrl #(.PRESET_M1(4'd0), .PRESET_M0(4'd1), .PRESET_S1(4'd0), .PRESET_S0(4'd0)) u_p0100 (
      .clk(clk), .rst_h(rst_h), .tick_1hz(tick_1hz), .start_pb(start_pb), .clr_pb(clr_pb),
      .m1(o_m1[2]), .m0(o_m0[2]), .s1(o_s1[2]), .s0(o_s0[2]),
      .state(o_st[2]), .done(o_done[2]), .led(o_led[2]));

   countdown_ctrl #(.PRESET_M1(4'd0), .PRESET_M0(4'd0), .PRESET_S1(4'd0), .PRESET_S0(4'd0)) u_p0000 (
      .clk(clk), .rst_h(rst_h), .tick_1hz(tick_1hz), .start_pb(start_pb), .clr_pb(clr_pb),
      .m1(o_m1[3]), .m0(o_m0[3]), .s1(o_s1[3]), .s0(o_s0[3]),
      .state(o_st[3]), .done(o_done[3]), .led(o_led[3]));

   // Reference model: remaining time as a plain seconds count per instance.
   int preset_s [NI] = '{30, 600, 60, 0};
   int secs [NI];
   int mode [NI];
   bit blink [NI];

   logic [NI-1:0][34:0] sbq [$];
   int checks = 0;
   int errors = 0;
   int cyc = 0;

   function automatic logic [34:0] expect_of(int i);
      int mm, ss;
      logic [15:0] l;
      mm = secs[i] / 60;
      ss = secs[i] % 60;
      case (mode[i])
         0: l = 16'h0000;
         1: l = 16'h0001;
         2: l = 16'h8001;
         default: l = blink[i] ? 16'hFFFF : 16'h0000;
      endcase
      return {4'(mm / 10), 4'(mm % 10), 4'(ss / 10), 4'(ss % 10), 2'(mode[i]), (mode[i] == 3), l};
   endfunction

   task automatic step(input bit r, input bit c, input bit s, input bit t);
      logic [NI-1:0][34:0] e;
      @(negedge clk);
      rst_h = r; clr_pb = c; start_pb = s; tick_1hz = t;
      cyc++;
      for (int i = 0; i < NI; i++) begin
         if (r || c) begin
            mode[i] = 0; secs[i] = preset_s[i]; blink[i] = 0;
         end else begin
            case (mode[i])
               0: if (s) begin
                     if (preset_s[i] == 0) begin mode[i] = 3; blink[i] = 1; end
                     else mode[i] = 1;
                  end
               1: begin
                     if (t) secs[i] = secs[i] - 1;
                     if (t && secs[i] == 0) begin mode[i] = 3; blink[i] = 1; end
                     else if (s) mode[i] = 2;
                  end
               2: if (s) mode[i] = 1;
               default: if (t) blink[i] = ~blink[i];
            endcase
         end
         e[i] = expect_of(i);
      end
      sbq.push_back(e);
   endtask

   task automatic ticks(input int n);
      for (int k = 0; k < n; k++) begin
         step(0, 0, 0, 1);
         step(0, 0, 0, 0);
      end
   endtask

   // Monitor: the outputs are presented every clock, so one scoreboard entry per edge.
   initial begin
      logic [NI-1:0][34:0] e;
      logic [34:0] got;
      forever begin
         @(posedge clk);
         #1;
         if (sbq.size() > 0) begin
            e = sbq.pop_front();
            for (int i = 0; i < NI; i++) begin
               got = {o_m1[i], o_m0[i], o_s1[i], o_s0[i], o_st[i], o_done[i], o_led[i]};
               checks++;
               if (got !== e[i]) begin
                  errors++;
                  $display("FAIL outputs inst=%0d time=%0t got m1m0s1s0=%h state=%0d done=%b led=%h required m1m0s1s0=%h state=%0d done=%b led=%h",
                           i, $time, got[34:19], got[18:17], got[16], got[15:0],
                           e[i][34:19], e[i][18:17], e[i][16], e[i][15:0]);
               end
            end
         end
      end
   end

   initial begin
      // Reset and first second
      step(1, 0, 0, 0);
      step(1, 0, 0, 0);
      step(0, 0, 0, 0);
      step(0, 0, 1, 0);
      ticks(1);
      // Run to 00:00, then blink on following ticks
      ticks(29);
      ticks(2);
      step(0, 0, 1, 0);
      step(0, 1, 0, 0);
      // Pause at 00:25, ticks ignored, resume
      step(0, 0, 1, 0);
      ticks(5);
      step(0, 0, 1, 0);
      ticks(5);
      step(0, 0, 1, 0);
      ticks(1);
      // Tick and start together at 00:01 and at 00:10
      step(0, 1, 0, 0);
      step(0, 0, 1, 0);
      ticks(29);
      step(0, 0, 1, 1);
      step(0, 1, 0, 0);
      step(0, 0, 1, 0);
      ticks(20);
      step(0, 0, 1, 1);
      step(0, 0, 0, 0);
      step(0, 0, 1, 0);
      step(0, 1, 0, 1);
      // Reset coinciding with a tick mid-run at 00:17
      step(0, 0, 1, 0);
      ticks(13);
      step(1, 0, 0, 1);
      step(0, 0, 0, 0);
      step(0, 0, 1, 0);
      ticks(30);
      step(0, 0, 1, 0);
      ticks(1);
      step(0, 1, 0, 0);
      // Randomized traffic
      for (int k = 0; k < 4000; k++) begin
         step(($urandom % 400) == 0, ($urandom % 60) == 0, ($urandom % 9) == 0, ($urandom % 3) == 0);
      end
      step(0, 0, 0, 0);
      for (int k = 0; k < 20 && sbq.size() > 0; k++) @(posedge clk);
      #2;
      if (sbq.size() != 0) begin
         errors++;
         $display("FAIL drain pending=%0d required=0", sbq.size());
      end
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
`default_nettype wire
